// File: rtl/pmic_pkg.sv
// Shared constants, state encoding and frame helpers for the PMIC status reporter.
// FAULT_REPORTER_SEQ_EN adds a sequence byte after the header (5-byte frames).
package pmic_pkg;

   localparam logic [7:0] FRAME_HEADER = 8'hA5;

   localparam int RAIL_12V    = 0;
   localparam int RAIL_5V     = 1;
   localparam int RAIL_3V3    = 2;
   localparam int RAIL_3V3ADC = 3;
   localparam int NUM_RAILS   = 4;
   localparam int NUM_STAGES  = 3;

   // Bit positions of each flag group inside the 16-bit status word
   localparam int STATUS_RAIL_LSB   = 0;
   localparam int STATUS_VFAULT_LSB = 4;
   localparam int STATUS_IFAULT_LSB = 8;
   localparam int STATUS_STAGE_LSB  = 12;
   localparam int STATUS_FPGA_BIT   = 15;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

`ifdef FAULT_REPORTER_SEQ_EN
   localparam int FRAME_LEN = 5;
`else
   localparam int FRAME_LEN = 4;
`endif

   function automatic logic [15:0] packStatus(
      input logic [NUM_RAILS-1:0]  railGood,
      input logic [NUM_RAILS-1:0]  voltageFault,
      input logic [NUM_RAILS-1:0]  currentFault,
      input logic [NUM_STAGES-1:0] stageGood,
      input logic                  fpgaFault
   );
      logic [15:0] s;
      s = '0;
      s[STATUS_RAIL_LSB   +: NUM_RAILS]  = railGood;
      s[STATUS_VFAULT_LSB +: NUM_RAILS]  = voltageFault;
      s[STATUS_IFAULT_LSB +: NUM_RAILS]  = currentFault;
      s[STATUS_STAGE_LSB  +: NUM_STAGES] = stageGood;
      s[STATUS_FPGA_BIT]                 = fpgaFault;
      return s;
   endfunction

`ifdef FAULT_REPORTER_SEQ_EN
   function automatic logic [7:0] frameByte(
      input logic [2:0]  idx,
      input logic [15:0] status,
      input logic [7:0]  seq
   );
      logic [7:0] b;
      case (idx)
         3'd0:    b = FRAME_HEADER;
         3'd1:    b = seq;
         3'd2:    b = status[15:8];
         3'd3:    b = status[7:0];
         default: b = FRAME_HEADER ^ seq ^ status[15:8] ^ status[7:0];
      endcase
      return b;
   endfunction
`else
   function automatic logic [7:0] frameByte(
      input logic [2:0]  idx,
      input logic [15:0] status
   );
      logic [7:0] b;
      case (idx)
         3'd0:    b = FRAME_HEADER;
         3'd1:    b = status[15:8];
         3'd2:    b = status[7:0];
         default: b = FRAME_HEADER ^ status[15:8] ^ status[7:0];
      endcase
      return b;
   endfunction
`endif

endpackage

// File: rtl/fault_reporter_cycle_timer.sv
// Clearable, enable-gated cycle counter; o_done is high while the count sits at
// TERMINAL_COUNT-1. A terminal count of 0 disables the timer entirely.
module cycle_timer #(
   parameter int unsigned TERMINAL_COUNT = 1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_done
);

   localparam int unsigned CW = (TERMINAL_COUNT > 1) ? $clog2(TERMINAL_COUNT) : 1;
   localparam logic [CW-1:0] LAST = (TERMINAL_COUNT > 0) ? CW'(TERMINAL_COUNT - 1) : '0;
   localparam logic ACTIVE = (TERMINAL_COUNT != 0);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign o_done = ACTIVE && (count_q == LAST);

   // Saturates at the terminal value so a missed clear never wraps into a false expiry
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable && ACTIVE && !o_done) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fault_reporter.sv
// Packs rail/stage flags into a status word and streams framed bytes to uart_tx on
// change, on heartbeat and after boot. FAULT_REPORTER_SEQ_EN adds a frame sequence byte.
module fault_reporter
   import pmic_pkg::*;
#(
   parameter int unsigned HEARTBEAT_CYCLES  = 4160000,
   parameter int unsigned TX_TIMEOUT_CYCLES = 12000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_railGood,
   input  logic [3:0] i_voltageFault,
   input  logic [3:0] i_currentFault,
   input  logic [2:0] i_stageGood,
   input  logic       i_fpgaFault,
   input  logic       i_txBusy,
   input  logic       i_txDone,
   output logic       o_txBegin,
   output logic [7:0] o_txData,
   output logic       o_busy,
   output logic       o_uartError
);

   localparam logic [2:0] LAST_INDEX = 3'(FRAME_LEN - 1);

   logic [1:0]  state_q,     state_d;
   logic [15:0] snapshot_q,  snapshot_d;
   logic [15:0] lastSent_q,  lastSent_d;
   logic        pending_q,   pending_d;
   logic [2:0]  index_q,     index_d;
   logic        txBegin_q,   txBegin_d;
   logic [7:0]  txData_q,    txData_d;
   logic        uartError_q, uartError_d;
`ifdef FAULT_REPORTER_SEQ_EN
   logic [7:0]  seq_q,       seq_d;
`endif

   logic [15:0] status;
   logic [7:0]  currentByte;
   logic        trigger;
   logic        hbClear;
   logic        hbDone;
   logic        toClear;
   logic        toDone;

   assign status = packStatus(i_railGood, i_voltageFault, i_currentFault,
                              i_stageGood, i_fpgaFault);

`ifdef FAULT_REPORTER_SEQ_EN
   assign currentByte = frameByte(index_q, snapshot_q, seq_q);
`else
   assign currentByte = frameByte(index_q, snapshot_q);
`endif

   // A heartbeat expiry coinciding with a status change still yields a single frame
   assign trigger = pending_q || (status != lastSent_q) || hbDone;

   cycle_timer #(
      .TERMINAL_COUNT(HEARTBEAT_CYCLES)
   ) heartbeatTimer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (hbClear),
      .i_enable (state_q == IDLE),
      .o_done   (hbDone)
   );

   cycle_timer #(
      .TERMINAL_COUNT(TX_TIMEOUT_CYCLES)
   ) timeoutTimer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (toClear),
      .i_enable (state_q == WAIT),
      .o_done   (toDone)
   );

   // Frame sequencer: the snapshot is frozen at frame start so bytes never mix two status words
   always_comb begin
      state_d     = state_q;
      snapshot_d  = snapshot_q;
      lastSent_d  = lastSent_q;
      pending_d   = pending_q;
      index_d     = index_q;
      txBegin_d   = 1'b0;
      txData_d    = txData_q;
      uartError_d = 1'b0;
      hbClear     = 1'b0;
      toClear     = 1'b0;
`ifdef FAULT_REPORTER_SEQ_EN
      seq_d       = seq_q;
`endif

      case (state_q)
         IDLE: begin
            if (trigger) begin
               snapshot_d = status;
               lastSent_d = status;
               pending_d  = 1'b0;
               hbClear    = 1'b1;
               index_d    = 3'd0;
               state_d    = SEND;
            end
         end

         SEND: begin
            if (!i_txBusy) begin
               txBegin_d = 1'b1;
               txData_d  = currentByte;
               toClear   = 1'b1;
               state_d   = WAIT;
            end
         end

         WAIT: begin
            if (i_txDone) begin
               if (index_q == LAST_INDEX) begin
                  state_d = IDLE;
`ifdef FAULT_REPORTER_SEQ_EN
                  seq_d   = seq_q + 8'd1;
`endif
               end else begin
                  index_d = index_q + 3'd1;
                  state_d = SEND;
               end
            end else if (toDone) begin
               // Abandon the frame; pending forces a full retry from the header
               uartError_d = 1'b1;
               pending_d   = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         snapshot_q  <= 16'h0000;
         lastSent_q  <= 16'h0000;
         pending_q   <= 1'b1;
         index_q     <= 3'd0;
         txBegin_q   <= 1'b0;
         txData_q    <= 8'h00;
         uartError_q <= 1'b0;
`ifdef FAULT_REPORTER_SEQ_EN
         seq_q       <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         snapshot_q  <= snapshot_d;
         lastSent_q  <= lastSent_d;
         pending_q   <= pending_d;
         index_q     <= index_d;
         txBegin_q   <= txBegin_d;
         txData_q    <= txData_d;
         uartError_q <= uartError_d;
`ifdef FAULT_REPORTER_SEQ_EN
         seq_q       <= seq_d;
`endif
      end
   end

   assign o_txBegin   = txBegin_q;
   assign o_txData    = txData_q;
   assign o_uartError = uartError_q;
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fault_reporter.sv
// Directed bench for fault_reporter: boot frame, change latency, mid-frame change,
// backpressure, transmit timeout, heartbeat and reset abort, against a simple uart_tx model.
module tb_fault_reporter;
   import pmic_pkg::*;

   localparam int HB_CYCLES  = 500;
   localparam int TO_CYCLES  = 100;
   localparam int DONE_DELAY = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] railGood;
   logic [3:0] voltageFault;
   logic [3:0] currentFault;
   logic [2:0] stageGood;
   logic       fpgaFault;
   logic       txBusy;
   logic       txDone;
   logic       txBegin;
   logic [7:0] txData;
   logic       busy;
   logic       uartError;

   int         checks = 0;
   int         errors = 0;
   int         cycle = 0;
   int         errPulses = 0;
   bit         modelEn = 1'b1;
   logic [7:0] tbSeq = 8'h00;
   logic [7:0] capBytes[$];

   fault_reporter #(
      .HEARTBEAT_CYCLES  (HB_CYCLES),
      .TX_TIMEOUT_CYCLES (TO_CYCLES)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_railGood     (railGood),
      .i_voltageFault (voltageFault),
      .i_currentFault (currentFault),
      .i_stageGood    (stageGood),
      .i_fpgaFault    (fpgaFault),
      .i_txBusy       (txBusy),
      .i_txDone       (txDone),
      .o_txBegin      (txBegin),
      .o_txData       (txData),
      .o_busy         (busy),
      .o_uartError    (uartError)
   );

   always #5 clk = ~clk;

   // Cycle stamp: number of rising edges seen so far
   always @(posedge clk) cycle <= cycle + 1;

   // Record every transmitted byte and every error pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (txBegin === 1'b1) capBytes.push_back(txData);
      if (uartError === 1'b1) errPulses <= errPulses + 1;
   end

   // uart_tx stand-in: answers each strobe with a done pulse DONE_DELAY cycles later
   initial begin
      txDone = 1'b0;
      forever begin
         @(negedge clk);
         if (modelEn && txBegin === 1'b1) begin
            repeat (DONE_DELAY) @(posedge clk);
            #1 txDone = 1'b1;
            @(posedge clk);
            #1 txDone = 1'b0;
         end
      end
   end

   function automatic logic [7:0] expByte(input logic [15:0] s, input logic [7:0] seq, input int idx);
      logic [7:0] b[5];
`ifdef FAULT_REPORTER_SEQ_EN
      b = '{8'hA5, seq, s[15:8], s[7:0], 8'hA5 ^ seq ^ s[15:8] ^ s[7:0]};
`else
      b = '{8'hA5, s[15:8], s[7:0], 8'hA5 ^ s[15:8] ^ s[7:0], seq};
`endif
      return b[idx];
   endfunction

   task automatic applyStimulus(input logic [15:0] s);
      railGood     = s[3:0];
      voltageFault = s[7:4];
      currentFault = s[11:8];
      stageGood    = s[14:12];
      fpgaFault    = s[15];
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic waitBegin(input int bound, output bit ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         #1;
         if (txBegin === 1'b1) begin
            ok = 1'b1;
            at = cycle;
            return;
         end
      end
   endtask

   task automatic waitFrames(input int nBytes, input int bound, output bit ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         #1;
         if (capBytes.size() >= nBytes && busy === 1'b0) begin
            ok = 1'b1;
            at = cycle;
            return;
         end
      end
   endtask

   task automatic test_reset();
      idleCycles(3);
      checks++; if (txBegin !== 1'b0) begin errors++; $display("[TB] FAIL reset txBegin: got %b expected 0", txBegin); end
      checks++; if (txData !== 8'h00) begin errors++; $display("[TB] FAIL reset txData: got %02h expected 00", txData); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
      checks++; if (uartError !== 1'b0) begin errors++; $display("[TB] FAIL reset uartError: got %b expected 0", uartError); end
   endtask

   task automatic test_boot();
      bit ok;
      int at;
      capBytes.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      waitFrames(FRAME_LEN, 400, ok, at);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL boot frame: got %0d bytes expected %0d", capBytes.size(), FRAME_LEN); end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++;
         if (capBytes[i] !== expByte(16'h000F, tbSeq, i)) begin
            errors++; $display("[TB] FAIL boot byte%0d: got %02h expected %02h", i, capBytes[i], expByte(16'h000F, tbSeq, i));
         end
      end
      tbSeq++;
      idleCycles(30);
      checks++; if (busy !== 1'b0 || capBytes.size() != FRAME_LEN) begin
         errors++; $display("[TB] FAIL boot quiet: busy %b bytes %0d expected busy 0 bytes %0d", busy, capBytes.size(), FRAME_LEN);
      end
   endtask

   task automatic test_change_latency();
      bit ok;
      int at;
      int edges;
      capBytes.delete();
      @(posedge clk);
      #1 applyStimulus(16'h002F);
      edges = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (txBegin === 1'b1) break;
      end
      checks++; if (edges != 2) begin errors++; $display("[TB] FAIL latency edges: got %0d expected 2", edges); end
      waitFrames(FRAME_LEN, 400, ok, at);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL latency frame: got %0d bytes expected %0d", capBytes.size(), FRAME_LEN); end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++;
         if (capBytes[i] !== expByte(16'h002F, tbSeq, i)) begin
            errors++; $display("[TB] FAIL latency byte%0d: got %02h expected %02h", i, capBytes[i], expByte(16'h002F, tbSeq, i));
         end
      end
      tbSeq++;
      idleCycles(40);
      checks++; if (capBytes.size() != FRAME_LEN) begin
         errors++; $display("[TB] FAIL latency single frame: got %0d bytes expected %0d", capBytes.size(), FRAME_LEN);
      end
   endtask

   task automatic test_done_ignored();
      capBytes.delete();
      @(posedge clk);
      #1 txDone = 1'b1;
      @(posedge clk);
      #1 txDone = 1'b0;
      idleCycles(20);
      checks++; if (capBytes.size() != 0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL idle done: bytes %0d busy %b expected 0 and 0", capBytes.size(), busy);
      end
   endtask

   task automatic test_mid_frame();
      bit ok;
      int at;
      @(posedge clk);
      #1 applyStimulus(16'h000F);
      capBytes.delete();
      waitFrames(FRAME_LEN, 400, ok, at);
      tbSeq++;
      idleCycles(10);
      capBytes.delete();
      @(posedge clk);
      #1 applyStimulus(16'h002F);
      for (int i = 0; i < 200 && capBytes.size() < 2; i++) idleCycles(1);
      applyStimulus(16'h812F);
      idleCycles(3);
      applyStimulus(16'h012F);
      waitFrames(2 * FRAME_LEN, 600, ok, at);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL midframe frames: got %0d bytes expected %0d", capBytes.size(), 2 * FRAME_LEN); end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++;
         if (capBytes[i] !== expByte(16'h002F, tbSeq, i)) begin
            errors++; $display("[TB] FAIL midframe old byte%0d: got %02h expected %02h", i, capBytes[i], expByte(16'h002F, tbSeq, i));
         end
      end
      tbSeq++;
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++;
         if (capBytes[FRAME_LEN + i] !== expByte(16'h012F, tbSeq, i)) begin
            errors++; $display("[TB] FAIL midframe new byte%0d: got %02h expected %02h", i, capBytes[FRAME_LEN + i], expByte(16'h012F, tbSeq, i));
         end
      end
      tbSeq++;
      idleCycles(40);
      checks++; if (capBytes.size() != 2 * FRAME_LEN) begin
         errors++; $display("[TB] FAIL midframe follow-up count: got %0d bytes expected %0d", capBytes.size(), 2 * FRAME_LEN);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int at;
      capBytes.delete();
      @(posedge clk);
      #1;
      txBusy = 1'b1;
      applyStimulus(16'h212F);
      idleCycles(50);
      checks++; if (capBytes.size() != 0 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL backpressure hold: bytes %0d busy %b expected 0 and 1", capBytes.size(), busy);
      end
      @(posedge clk);
      #1 txBusy = 1'b0;
      waitBegin(5, ok, at);
      checks++; if (!ok || txData !== 8'hA5) begin
         errors++; $display("[TB] FAIL backpressure strobe: begin %b data %02h expected 1 and a5", ok, txData);
      end
      #3;
      checks++; if (txData !== 8'hA5 || txBegin !== 1'b1) begin
         errors++; $display("[TB] FAIL backpressure stable: data %02h begin %b expected a5 and 1", txData, txBegin);
      end
      idleCycles(10);
      checks++; if (capBytes.size() != 1) begin
         errors++; $display("[TB] FAIL backpressure single strobe: got %0d bytes expected 1", capBytes.size());
      end
      waitFrames(FRAME_LEN, 400, ok, at);
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++;
         if (capBytes[i] !== expByte(16'h212F, tbSeq, i)) begin
            errors++; $display("[TB] FAIL backpressure byte%0d: got %02h expected %02h", i, capBytes[i], expByte(16'h212F, tbSeq, i));
         end
      end
      tbSeq++;
      idleCycles(10);
   endtask

   task automatic test_timeout();
      bit ok;
      int beginAt;
      int errAt;
      int errBefore;
      int at;
      capBytes.delete();
      modelEn = 1'b0;
      errBefore = errPulses;
      @(posedge clk);
      #1 applyStimulus(16'h612F);
      waitBegin(10, ok, beginAt);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout first strobe: got none expected one"); end
      errAt = 0;
      for (int i = 0; i < 200; i++) begin
         idleCycles(1);
         if (uartError === 1'b1) begin errAt = cycle; break; end
      end
      checks++; if (errAt - beginAt != TO_CYCLES) begin
         errors++; $display("[TB] FAIL timeout delay: got %0d cycles expected %0d", errAt - beginAt, TO_CYCLES);
      end
      idleCycles(1);
      modelEn = 1'b1;
      checks++; if (uartError !== 1'b0) begin errors++; $display("[TB] FAIL timeout pulse width: got %b expected 0", uartError); end
      waitFrames(1 + FRAME_LEN, 600, ok, at);
      checks++; if (!ok || capBytes.size() != 1 + FRAME_LEN) begin
         errors++; $display("[TB] FAIL timeout retry count: got %0d bytes expected %0d", capBytes.size(), 1 + FRAME_LEN);
      end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++;
         if (capBytes[1 + i] !== expByte(16'h612F, tbSeq, i)) begin
            errors++; $display("[TB] FAIL timeout retry byte%0d: got %02h expected %02h", i, capBytes[1 + i], expByte(16'h612F, tbSeq, i));
         end
      end
      tbSeq++;
      checks++; if (errPulses - errBefore != 1) begin
         errors++; $display("[TB] FAIL timeout error pulses: got %0d expected 1", errPulses - errBefore);
      end
   endtask

   task automatic test_heartbeat();
      bit ok;
      int idleAt;
      int beginAt;
      int at;
      idleAt = cycle;
      for (int k = 0; k < 2; k++) begin
         capBytes.delete();
         waitBegin(700, ok, beginAt);
         checks++; if (!ok || beginAt - idleAt != HB_CYCLES + 1) begin
            errors++; $display("[TB] FAIL heartbeat%0d interval: got %0d cycles expected %0d", k, beginAt - idleAt, HB_CYCLES + 1);
         end
         waitFrames(FRAME_LEN, 400, ok, idleAt);
         for (int i = 0; i < FRAME_LEN; i++) begin
            checks++;
            if (capBytes[i] !== expByte(16'h612F, tbSeq, i)) begin
               errors++; $display("[TB] FAIL heartbeat%0d byte%0d: got %02h expected %02h", k, i, capBytes[i], expByte(16'h612F, tbSeq, i));
            end
         end
         tbSeq++;
      end
      at = 0;
   endtask

   task automatic test_reset_abort();
      bit ok;
      int at;
      capBytes.delete();
      @(posedge clk);
      #1 applyStimulus(16'hE12F);
      waitBegin(10, ok, at);
      reset = 1'b1;
      #1;
      checks++; if (txBegin !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL abort async: begin %b busy %b expected 0 and 0", txBegin, busy);
      end
      idleCycles(40);
      capBytes.delete();
      tbSeq = 8'h00;
      @(posedge clk);
      #1 reset = 1'b0;
      waitFrames(FRAME_LEN, 400, ok, at);
      checks++; if (!ok || capBytes.size() != FRAME_LEN) begin
         errors++; $display("[TB] FAIL abort boot count: got %0d bytes expected %0d", capBytes.size(), FRAME_LEN);
      end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++;
         if (capBytes[i] !== expByte(16'hE12F, tbSeq, i)) begin
            errors++; $display("[TB] FAIL abort boot byte%0d: got %02h expected %02h", i, capBytes[i], expByte(16'hE12F, tbSeq, i));
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      txBusy = 1'b0;
      applyStimulus(16'h000F);
      test_reset();
      test_boot();
      test_change_latency();
      test_done_ignored();
      test_mid_frame();
      test_backpressure();
      test_timeout();
      test_heartbeat();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
